add_round_key_stream: RTL and testbench
=======================================

# add_round_key_stream

Streaming, parametrised AddRoundKey stage for the AES datapath. It holds a loadable round-key table and XORs each incoming state word with the key of the round that travels with it. Results are buffered in a 2-entry output queue under valid/ready handshakes. It sits between the round-function pipeline (SubBytes/ShiftRows/MixColumns) and the next round or ciphertext output, and replaces the purely combinational XOR with a back-pressure-aware, table-driven unit.

## Interface

Parameters:
- WIDTH, 128: state and key width in bits.
- NUM_ROUNDS, 11: number of key-table entries (11 for AES-128, 13 for AES-192, 15 for AES-256).
- RW, $clog2(NUM_ROUNDS): round-index width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_we  in  1  write key_data into entry key_addr.
- key_addr  in  RW  key-table index.
- key_data  in  WIDTH  round key.
- key_clear  in  1  invalidate all key entries.
- keys_loaded  out  NUM_ROUNDS  per-entry valid mask.
- in_valid  in  1  input word present.
- in_ready  out  1  unit can accept.
- in_state  in  WIDTH  state word.
- in_round  in  RW  round index for this word.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- out_state  out  WIDTH  state XOR round key.
- out_round  out  RW  round index echoed.
- out_err  out  1  entry missing or index out of range; state passed through unXORed.

## Operation

- A transfer on either side happens when valid and ready are both high on a rising edge.
- On an input transfer:
  - If in_round < NUM_ROUNDS and keys_loaded[in_round] = 1: result = in_state ^ key[in_round], err = 0.
  - Otherwise: result = in_state, err = 1.
  - The result, round and err are pushed into the output queue.
- Output queue: 2-entry FIFO, order preserved. out_* always shows the head entry, and the head pops on an output transfer.
- in_ready = (count < 2), registered. A push and a pop in the same cycle with count = 2 is not possible, because in_ready is 0. With count = 1, a simultaneous push and pop leaves count = 1.
- Key writes:
  - key_we sets key[key_addr] and sets keys_loaded[key_addr]. Writes with key_addr >= NUM_ROUNDS are ignored.
  - key_clear zeroes keys_loaded. Key contents are retained but unusable.
  - key_clear and key_we in the same cycle: clear wins and the mask ends all-zero. The data write still occurs.
- Read-before-write: an input transfer in the same cycle as a key_we to the same entry uses the old key and old mask bit.

## Timing

- Latency: a word accepted at edge N is visible on out_* after edge N, with out_valid = 1 in cycle N+1 if the queue was empty.
- Throughput: one word per cycle while out_ready = 1.
- in_ready drops the cycle after the queue fills and rises the cycle after a pop frees an entry.
- out_valid, once high, holds with stable out_* until popped.
- Reset values (asynchronous assertion, synchronous-edge deassertion use):
  - out_valid = 0, out_state = 0, out_round = 0, out_err = 0.
  - in_ready = 1, keys_loaded = 0, count = 0.
  - The key array is not reset.
- Reset mid-operation: queued words are discarded and the key mask is cleared, so keys must be reloaded.

## Structure

- Shared package aes_pkg:
  - AES_BLOCK_W = 128.
  - Round-count constants AES128_ROUNDS = 11, AES192_ROUNDS = 13, AES256_ROUNDS = 15.
  - Typedef for the queue entry {state, round, err}.
- Sub-module ark_skid_fifo: 2-entry FIFO with registered ready, parametrised on entry width.
- The top level holds the key array, the mask, and the XOR/select logic.

## Test plan

- Known-answer, round 0: load key[0] = 2b7e151628aed2a6abf7158809cf4f3c. Send state 3243f6a8885a308d313198a2e0370734 with round 0. Expect out_state 193de3bea0f4e22b9ac68d2ae9f84808, err 0, one cycle later.
- Known-answer, round 1: load key[1] = a0fafe1788542cb123a339392a6c7605. Send 046681e5e0cb199a48f8d37a2806264c. Expect a49c7ff2689f352b6b5bea43026a5049.
- Back-pressure: hold out_ready = 0 and stream 3 words. Expect in_ready = 0 after the 2nd accept. Release out_ready and expect all 3 out in order with none lost or duplicated.
- Missing key / out of range:
  - Round 5 is unloaded: expect out_state = in_state, err 1.
  - in_round = 15 with NUM_ROUNDS = 11: expect the same.
  - key_clear followed by round 0: expect err 1.
- Same-cycle hazards:
  - key_we to entry 1 with an input on round 1 in the same cycle: expect the old key to be used.
  - key_clear and key_we together: expect keys_loaded = 0.
- Reset mid-stream: assert rst_n = 0 with 2 words queued. Expect out_valid = 0 immediately, and after release in_ready = 1 and keys_loaded = 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the AddRoundKey output-queue entry layout.
package aes_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES128_ROUNDS = 11;
    localparam int AES192_ROUNDS = 13;
    localparam int AES256_ROUNDS = 15;
    localparam int AES128_RW     = $clog2(AES128_ROUNDS);

    // Queue entry for the default AES-128 configuration: {state, round, err}
    typedef struct packed {
        logic [AES_BLOCK_W-1:0] state;
        logic [AES128_RW-1:0]   round;
        logic                   err;
    } ark_entry_t;

    // Packed width of a {state, round, err} entry for arbitrary widths
    function automatic int ark_entry_w(input int w, input int rw);
        return w + rw + 1;
    endfunction

endpackage

// File: rtl/ark_skid_fifo.sv
// Two-entry in-order FIFO with a registered ready. The head entry is always
// presented on out_data; ready is computed from the next occupancy so it
// drops the cycle after the queue fills and rises the cycle after a pop.
module ark_skid_fifo #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [DW-1:0] slot_p0;   // head
    logic [DW-1:0] slot_p1;   // second entry
    logic [1:0]    count;
    logic [1:0]    count_nxt;
    logic          push;
    logic          pop;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = slot_p0;

    // Next occupancy; push+pop together leaves the count unchanged
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // Occupancy, registered ready and slot shifting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            in_ready <= 1'b1;
            slot_p0  <= '0;
            slot_p1  <= '0;
        end else begin
            count    <= count_nxt;
            in_ready <= (count_nxt < 2'd2);
            if (pop) begin
                if (push && count == 2'd1) begin
                    slot_p0 <= in_data;
                end else begin
                    slot_p0 <= slot_p1;
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    slot_p0 <= in_data;
                end else begin
                    slot_p1 <= in_data;
                end
            end
        end
    end

endmodule

// File: rtl/add_round_key_stream.sv
// Streaming AddRoundKey: a loadable round-key table with a per-entry valid
// mask, XORed against each incoming state word by its round index. Words
// whose key is missing or whose index is out of range pass through unXORed
// with err set. Results are queued in a two-entry FIFO.
module add_round_key_stream
    import aes_pkg::*;
#(
    parameter int WIDTH      = AES_BLOCK_W,
    parameter int NUM_ROUNDS = AES128_ROUNDS,
    parameter int RW         = $clog2(NUM_ROUNDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_we,
    input  logic [RW-1:0]         key_addr,
    input  logic [WIDTH-1:0]      key_data,
    input  logic                  key_clear,
    output logic [NUM_ROUNDS-1:0] keys_loaded,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_state,
    input  logic [RW-1:0]         in_round,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_state,
    output logic [RW-1:0]         out_round,
    output logic                  out_err
);

    localparam int EW = ark_entry_w(WIDTH, RW);

    typedef struct packed {
        logic [WIDTH-1:0] state;
        logic [RW-1:0]    round;
        logic             err;
    } entry_t;

    logic [WIDTH-1:0]      key_mem [NUM_ROUNDS];
    logic [NUM_ROUNDS-1:0] mask;
    logic [WIDTH-1:0]      key_sel;
    logic                  hit;
    entry_t                entry_p0;
    logic [EW-1:0]         head_raw;
    entry_t                head_p1;

    assign keys_loaded = mask;

    // Key lookup against current table contents (read-before-write); an
    // index that matches no entry leaves hit low
    always_comb begin
        key_sel = '0;
        hit     = 1'b0;
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            if (in_round == RW'(i)) begin
                key_sel = key_mem[i];
                hit     = mask[i];
            end
        end
    end

    // Stage p0: XOR or pass-through selection, entry enters the queue
    always_comb begin
        entry_p0.state = hit ? (in_state ^ key_sel) : in_state;
        entry_p0.round = in_round;
        entry_p0.err   = ~hit;
    end

    // Key storage; not reset, and written even when a clear is requested
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            if (key_we && key_addr == RW'(i)) begin
                key_mem[i] <= key_data;
            end
        end
    end

    // Valid mask; clear takes priority over a same-cycle write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
        end else if (key_clear) begin
            mask <= '0;
        end else if (key_we) begin
            for (int i = 0; i < NUM_ROUNDS; i++) begin
                if (key_addr == RW'(i)) begin
                    mask[i] <= 1'b1;
                end
            end
        end
    end

    ark_skid_fifo #(
        .DW (EW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (entry_p0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_raw)
    );

    // Stage p1: queue head drives the outputs
    assign head_p1   = head_raw;
    assign out_state = head_p1.state;
    assign out_round = head_p1.round;
    assign out_err   = head_p1.err;

endmodule

// File: tb/tb_add_round_key_stream.sv
// Self-checking bench for add_round_key_stream: scoreboard monitor plus
// per-scenario tasks with inline checks.
module tb_add_round_key_stream;
    import aes_pkg::*;

    localparam int W  = 128;
    localparam int NR = 11;
    localparam int RW = 4;

    localparam logic [W-1:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [W-1:0] S0  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [W-1:0] R0  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [W-1:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [W-1:0] S1  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [W-1:0] R1  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [W-1:0] K1B = 128'h0123456789abcdeffedcba9876543210;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          key_we = 1'b0;
    logic [RW-1:0] key_addr = '0;
    logic [W-1:0]  key_data = '0;
    logic          key_clear = 1'b0;
    logic [NR-1:0] keys_loaded;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_state = '0;
    logic [RW-1:0] in_round = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_state;
    logic [RW-1:0] out_round;
    logic          out_err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0]  key_m [NR];
    logic [NR-1:0] mask_m = '0;
    ark_entry_t    sb [$];

    add_round_key_stream #(
        .WIDTH      (W),
        .NUM_ROUNDS (NR),
        .RW         (RW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_we      (key_we),
        .key_addr    (key_addr),
        .key_data    (key_data),
        .key_clear   (key_clear),
        .keys_loaded (keys_loaded),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_state    (in_state),
        .in_round    (in_round),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_state   (out_state),
        .out_round   (out_round),
        .out_err     (out_err)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: samples on the falling edge, mid-cycle
    always @(negedge clk) begin
        ark_entry_t e;
        ark_entry_t g;
        int r;
        if (!rst_n) begin
            mask_m = '0;
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got state=%h round=%0d err=%0b with nothing expected",
                             out_state, out_round, out_err);
                end else begin
                    e = sb.pop_front();
                    g.state = out_state;
                    g.round = out_round;
                    g.err   = out_err;
                    if (g !== e) begin
                        bad++;
                        $display("FAIL sb_entry: got state=%h round=%0d err=%0b expected state=%h round=%0d err=%0b",
                                 g.state, g.round, g.err, e.state, e.round, e.err);
                    end
                end
            end
            if (in_valid && in_ready) begin
                r = int'(in_round);
                e.round = in_round;
                if (r < NR && mask_m[r]) begin
                    e.state = in_state ^ key_m[r];
                    e.err   = 1'b0;
                end else begin
                    e.state = in_state;
                    e.err   = 1'b1;
                end
                sb.push_back(e);
            end
            if (key_we && int'(key_addr) < NR) key_m[int'(key_addr)] = key_data;
            if (key_clear) mask_m = '0;
            else if (key_we && int'(key_addr) < NR) mask_m[int'(key_addr)] = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [RW-1:0] a, input logic [W-1:0] d);
        key_we = 1'b1; key_addr = a; key_data = d;
        tick();
        key_we = 1'b0;
    endtask

    // Present one word and hold it until accepted (bounded)
    task automatic send(input logic [W-1:0] s, input logic [RW-1:0] r);
        int n;
        in_valid = 1'b1; in_state = s; in_round = r;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("FAIL drain: out_valid=%0b pending=%0d, required 0 and 0", out_valid, sb.size());
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %0b required 1", in_ready); end
        total++;
        if (keys_loaded !== '0) begin bad++; $display("FAIL rst_keys_loaded: got %h required 0", keys_loaded); end
        total++;
        if (out_state !== '0 || out_round !== '0 || out_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_out_data: got state=%h round=%0d err=%0b required zeros", out_state, out_round, out_err);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_kat_round0();
        load_key(4'd0, K0);
        send(S0, 4'd0);
        total++;
        if (out_valid !== 1'b1 || out_state !== R0 || out_err !== 1'b0) begin
            bad++;
            $display("FAIL kat0: got valid=%0b state=%h err=%0b required 1 %h 0", out_valid, out_state, out_err, R0);
        end
        drain();
    endtask

    task automatic test_kat_round1();
        load_key(4'd1, K1);
        total++;
        if (keys_loaded !== 11'h003) begin bad++; $display("FAIL mask_after_load: got %h required 003", keys_loaded); end
        send(S1, 4'd1);
        total++;
        if (out_state !== R1 || out_round !== 4'd1 || out_err !== 1'b0) begin
            bad++;
            $display("FAIL kat1: got state=%h round=%0d err=%0b required %h 1 0", out_state, out_round, out_err, R1);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            in_round = RW'(i % 3);
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %0b required 1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w0;
        w0 = 128'h00112233445566778899aabbccddeeff;
        out_ready = 1'b0;
        in_valid = 1'b1; in_state = w0; in_round = 4'd0;
        tick();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_1: got %0b required 1", in_ready); end
        in_state = 128'h1; in_round = 4'd1;
        tick();
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_2: got %0b required 0", in_ready); end
        in_state = 128'h2; in_round = 4'd5;
        tick();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_state !== (w0 ^ K0)) begin
            bad++;
            $display("FAIL bp_hold: got ready=%0b valid=%0b state=%h required 0 1 %h", in_ready, out_valid, out_state, w0 ^ K0);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_reopen: got %0b required 1", in_ready); end
        tick();
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_missing();
        send(128'hdeadbeef, 4'd5);
        total++;
        if (out_state !== 128'hdeadbeef || out_err !== 1'b1) begin
            bad++;
            $display("FAIL miss_r5: got state=%h err=%0b required deadbeef 1", out_state, out_err);
        end
        drain();
        send(128'hcafe, 4'd15);
        total++;
        if (out_state !== 128'hcafe || out_err !== 1'b1 || out_round !== 4'd15) begin
            bad++;
            $display("FAIL miss_r15: got state=%h round=%0d err=%0b required cafe 15 1", out_state, out_round, out_err);
        end
        drain();
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        total++;
        if (keys_loaded !== '0) begin bad++; $display("FAIL clear_mask: got %h required 0", keys_loaded); end
        send(S0, 4'd0);
        total++;
        if (out_state !== S0 || out_err !== 1'b1) begin
            bad++;
            $display("FAIL clear_r0: got state=%h err=%0b required %h 1", out_state, out_err, S0);
        end
        drain();
    endtask

    task automatic test_hazard();
        load_key(4'd1, K1);
        key_we = 1'b1; key_addr = 4'd1; key_data = K1B;
        in_valid = 1'b1; in_state = S1; in_round = 4'd1;
        tick();
        key_we = 1'b0; in_valid = 1'b0;
        total++;
        if (out_state !== R1 || out_err !== 1'b0) begin
            bad++;
            $display("FAIL rbw_key: got state=%h err=%0b required %h 0", out_state, out_err, R1);
        end
        drain();
        key_we = 1'b1; key_addr = 4'd2; key_data = K0;
        in_valid = 1'b1; in_state = S0; in_round = 4'd2;
        tick();
        key_we = 1'b0; in_valid = 1'b0;
        total++;
        if (out_state !== S0 || out_err !== 1'b1) begin
            bad++;
            $display("FAIL rbw_mask: got state=%h err=%0b required %h 1", out_state, out_err, S0);
        end
        drain();
        send(S1, 4'd1);
        total++;
        if (out_state !== (S1 ^ K1B)) begin
            bad++;
            $display("FAIL new_key: got %h required %h", out_state, S1 ^ K1B);
        end
        drain();
        key_clear = 1'b1; key_we = 1'b1; key_addr = 4'd3; key_data = K1;
        tick();
        key_clear = 1'b0; key_we = 1'b0;
        total++;
        if (keys_loaded !== '0) begin bad++; $display("FAIL clear_and_we: got %h required 0", keys_loaded); end
    endtask

    task automatic test_reset_midstream();
        load_key(4'd0, K0);
        out_ready = 1'b0;
        send(S0, 4'd0);
        send(S1, 4'd0);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_full: got ready=%0b valid=%0b required 0 1", in_ready, out_valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %0b required 0", out_valid); end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1 || keys_loaded !== '0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_after: got ready=%0b mask=%h valid=%0b required 1 0 0", in_ready, keys_loaded, out_valid);
        end
        out_ready = 1'b1;
        drain();
    endtask

    initial begin
        test_reset();
        test_kat_round0();
        test_kat_round1();
        test_back_to_back();
        test_backpressure();
        test_missing();
        test_hazard();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
